// File: rtl/ex_mem_latch_pkg.sv
// Shared EX/MEM pipeline definitions: control-field widths, bit positions
// within the wb/m control bundles, and the latch FSM state encoding.
package ex_mem_latch_pkg;

  localparam int unsigned WB_W = 2;
  localparam int unsigned M_W  = 3;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  localparam int unsigned M_BRANCH   = 2;
  localparam int unsigned M_MEMREAD  = 1;
  localparam int unsigned M_MEMWRITE = 0;

  localparam int unsigned PERF_W = 32;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } ex_mem_state_e;

endpackage : ex_mem_latch_pkg

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with stall, flush and taken-branch squash.
// Optional bubble counter output enabled by defining EX_MEM_PERF_EN.
module ex_mem_latch
  import ex_mem_latch_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [WB_W-1:0]   ex_wb_ctl,
  input  logic [M_W-1:0]    ex_m_ctl,
  input  logic [DATA_W-1:0] ex_add_result,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rdata2,
  input  logic [REG_AW-1:0] ex_dest,
  output logic              mem_valid,
  output logic [WB_W-1:0]   mem_wb_ctl,
  output logic              mem_branch,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [DATA_W-1:0] mem_add_result,
  output logic              mem_zero,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_rdata2,
  output logic [REG_AW-1:0] mem_dest,
  output logic              mem_pcsrc
`ifdef EX_MEM_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_bubble_count
`endif
);

  logic              valid_q,  valid_d;
  logic [WB_W-1:0]   wb_ctl_q, wb_ctl_d;
  logic [M_W-1:0]    m_ctl_q,  m_ctl_d;
  logic [DATA_W-1:0] add_q,    add_d;
  logic              zero_q,   zero_d;
  logic [DATA_W-1:0] alu_q,    alu_d;
  logic [DATA_W-1:0] rdata2_q, rdata2_d;
  logic [REG_AW-1:0] dest_q,   dest_d;
  ex_mem_state_e     state_q,  state_d;

  logic load;
  logic bubble;
  logic pcsrc;

  assign pcsrc = valid_q & m_ctl_q[M_BRANCH] & zero_q;

  // flush overrides stall, so a flushed edge always advances the latch.
  assign load = ~stall | flush;

  always_comb begin
    state_d = state_q;
    if (load) begin
      unique case (state_q)
        ST_RUN:  if (pcsrc) state_d = ST_KILL;
        ST_KILL: state_d = ST_RUN;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // The edge that enters KILL is the one whose capture gets squashed, so a
  // taken branch kills exactly the instruction directly behind it.
  assign bubble = flush | ~ex_valid | (state_d == ST_KILL);

  always_comb begin
    valid_d  = valid_q;
    wb_ctl_d = wb_ctl_q;
    m_ctl_d  = m_ctl_q;
    add_d    = add_q;
    zero_d   = zero_q;
    alu_d    = alu_q;
    rdata2_d = rdata2_q;
    dest_d   = dest_q;
    if (load) begin
      if (bubble) begin
        valid_d  = 1'b0;
        wb_ctl_d = '0;
        m_ctl_d  = '0;
        add_d    = '0;
        zero_d   = 1'b0;
        alu_d    = '0;
        rdata2_d = '0;
        dest_d   = '0;
      end else begin
        valid_d  = 1'b1;
        wb_ctl_d = ex_wb_ctl;
        m_ctl_d  = ex_m_ctl;
        add_d    = ex_add_result;
        zero_d   = ex_zero;
        alu_d    = ex_alu_result;
        rdata2_d = ex_rdata2;
        dest_d   = ex_dest;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      wb_ctl_q <= '0;
      m_ctl_q  <= '0;
      add_q    <= '0;
      zero_q   <= 1'b0;
      alu_q    <= '0;
      rdata2_q <= '0;
      dest_q   <= '0;
      state_q  <= ST_RUN;
    end else begin
      valid_q  <= valid_d;
      wb_ctl_q <= wb_ctl_d;
      m_ctl_q  <= m_ctl_d;
      add_q    <= add_d;
      zero_q   <= zero_d;
      alu_q    <= alu_d;
      rdata2_q <= rdata2_d;
      dest_q   <= dest_d;
      state_q  <= state_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_wb_ctl     = wb_ctl_q;
  assign mem_branch     = m_ctl_q[M_BRANCH];
  assign mem_memread    = m_ctl_q[M_MEMREAD];
  assign mem_memwrite   = m_ctl_q[M_MEMWRITE];
  assign mem_add_result = add_q;
  assign mem_zero       = zero_q;
  assign mem_alu_result = alu_q;
  assign mem_rdata2     = rdata2_q;
  assign mem_dest       = dest_q;
  assign mem_pcsrc      = pcsrc;

`ifdef EX_MEM_PERF_EN
  logic [PERF_W-1:0] perf_cnt_q, perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (load && bubble) perf_cnt_d = perf_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_cnt_q <= '0;
    else        perf_cnt_q <= perf_cnt_d;
  end

  assign perf_bubble_count = perf_cnt_q;
`endif

endmodule : ex_mem_latch

// File: tb/tb_ex_mem_latch.sv
// Directed self-checking bench for ex_mem_latch.
module tb_ex_mem_latch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [1:0]  ex_wb_ctl;
  logic [2:0]  ex_m_ctl;
  logic [31:0] ex_add_result;
  logic        ex_zero;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rdata2;
  logic [4:0]  ex_dest;
  logic        mem_valid;
  logic [1:0]  mem_wb_ctl;
  logic        mem_branch;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [31:0] mem_add_result;
  logic        mem_zero;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_rdata2;
  logic [4:0]  mem_dest;
  logic        mem_pcsrc;
`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_bubble_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem_latch #(.DATA_W(32), .REG_AW(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_wb_ctl      (ex_wb_ctl),
    .ex_m_ctl       (ex_m_ctl),
    .ex_add_result  (ex_add_result),
    .ex_zero        (ex_zero),
    .ex_alu_result  (ex_alu_result),
    .ex_rdata2      (ex_rdata2),
    .ex_dest        (ex_dest),
    .mem_valid      (mem_valid),
    .mem_wb_ctl     (mem_wb_ctl),
    .mem_branch     (mem_branch),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .mem_add_result (mem_add_result),
    .mem_zero       (mem_zero),
    .mem_alu_result (mem_alu_result),
    .mem_rdata2     (mem_rdata2),
    .mem_dest       (mem_dest),
    .mem_pcsrc      (mem_pcsrc)
`ifdef EX_MEM_PERF_EN
    ,
    .perf_bubble_count (perf_bubble_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic [1:0] wb, input logic [2:0] m,
                        input logic [31:0] add, input logic z, input logic [31:0] alu,
                        input logic [31:0] rd2, input logic [4:0] dst);
    ex_valid      = v;
    ex_wb_ctl     = wb;
    ex_m_ctl      = m;
    ex_add_result = add;
    ex_zero       = z;
    ex_alu_result = alu;
    ex_rdata2     = rd2;
    ex_dest       = dst;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    set_ex(1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
    #12;
    check("rst_valid",  {63'd0, mem_valid}, 64'd0);
    check("rst_wb",     {62'd0, mem_wb_ctl}, 64'd0);
    check("rst_mctl",   {61'd0, mem_branch, mem_memread, mem_memwrite}, 64'd0);
    check("rst_add",    {32'd0, mem_add_result}, 64'd0);
    check("rst_alu",    {32'd0, mem_alu_result}, 64'd0);
    check("rst_rdata2", {32'd0, mem_rdata2}, 64'd0);
    check("rst_dest",   {59'd0, mem_dest}, 64'd0);
    check("rst_pcsrc",  {63'd0, mem_pcsrc}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Basic capture
    set_ex(1'b1, 2'b10, 3'b000, 32'h0, 1'b0, 32'h0000_1234, 32'h0000_AAAA, 5'd5);
    step();
    check("cap_alu",    {32'd0, mem_alu_result}, 64'h1234);
    check("cap_dest",   {59'd0, mem_dest}, 64'd5);
    check("cap_valid",  {63'd0, mem_valid}, 64'd1);
    check("cap_wb",     {62'd0, mem_wb_ctl}, 64'd2);
    check("cap_rdata2", {32'd0, mem_rdata2}, 64'hAAAA);
    check("cap_pcsrc",  {63'd0, mem_pcsrc}, 64'd0);

    // Stall three cycles while inputs change
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 2'b01, 3'b111, 32'h100 + i, 1'b1, 32'h200 + i, 32'h300 + i, 5'(i + 10));
      step();
      check("stall_alu",   {32'd0, mem_alu_result}, 64'h1234);
      check("stall_dest",  {59'd0, mem_dest}, 64'd5);
      check("stall_wb",    {62'd0, mem_wb_ctl}, 64'd2);
      check("stall_pcsrc", {63'd0, mem_pcsrc}, 64'd0);
    end
    stall = 1'b0;

    // ex_valid=0 inserts a bubble with zeroed data
    set_ex(1'b0, 2'b11, 3'b111, 32'h44, 1'b1, 32'hBEEF, 32'h1, 5'd9);
    step();
    check("inv_valid", {63'd0, mem_valid}, 64'd0);
    check("inv_wb",    {62'd0, mem_wb_ctl}, 64'd0);
    check("inv_mread", {63'd0, mem_memread}, 64'd0);
    check("inv_alu",   {32'd0, mem_alu_result}, 64'd0);
    check("inv_pcsrc", {63'd0, mem_pcsrc}, 64'd0);

    // Taken branch squashes exactly the next instruction
    set_ex(1'b1, 2'b00, 3'b100, 32'h0000_0040, 1'b1, 32'h8, 32'h0, 5'd0);
    step();
    check("br_pcsrc",  {63'd0, mem_pcsrc}, 64'd1);
    check("br_add",    {32'd0, mem_add_result}, 64'h40);
    check("br_branch", {63'd0, mem_branch}, 64'd1);
    set_ex(1'b1, 2'b10, 3'b001, 32'h0, 1'b0, 32'h55, 32'h66, 5'd7);
    step();
    check("sq_valid",  {63'd0, mem_valid}, 64'd0);
    check("sq_mwrite", {63'd0, mem_memwrite}, 64'd0);
    check("sq_pcsrc",  {63'd0, mem_pcsrc}, 64'd0);
    check("sq_alu",    {32'd0, mem_alu_result}, 64'd0);
    step();
    check("post_valid",  {63'd0, mem_valid}, 64'd1);
    check("post_mwrite", {63'd0, mem_memwrite}, 64'd1);
    check("post_alu",    {32'd0, mem_alu_result}, 64'h55);
    check("post_dest",   {59'd0, mem_dest}, 64'd7);

    // Taken branch held by stall: pcsrc stays high, squash waits for release
    set_ex(1'b1, 2'b00, 3'b100, 32'h0000_0080, 1'b1, 32'h0, 32'h0, 5'd0);
    step();
    check("brs_pcsrc0", {63'd0, mem_pcsrc}, 64'd1);
    stall = 1'b1;
    set_ex(1'b1, 2'b10, 3'b010, 32'h0, 1'b0, 32'hA1, 32'h0, 5'd3);
    step();
    step();
    check("brs_pcsrc_held", {63'd0, mem_pcsrc}, 64'd1);
    check("brs_add_held",   {32'd0, mem_add_result}, 64'h80);
    stall = 1'b0;
    step();
    check("brs_sq_valid", {63'd0, mem_valid}, 64'd0);
    check("brs_sq_pcsrc", {63'd0, mem_pcsrc}, 64'd0);
    step();
    check("brs_post_valid", {63'd0, mem_valid}, 64'd1);
    check("brs_post_mread", {63'd0, mem_memread}, 64'd1);
    check("brs_post_alu",   {32'd0, mem_alu_result}, 64'hA1);

    // flush wins over stall
    set_ex(1'b1, 2'b00, 3'b001, 32'h0, 1'b0, 32'h77, 32'h88, 5'd3);
    stall = 1'b1;
    flush = 1'b1;
    step();
    check("fs_valid",  {63'd0, mem_valid}, 64'd0);
    check("fs_mwrite", {63'd0, mem_memwrite}, 64'd0);
    check("fs_alu",    {32'd0, mem_alu_result}, 64'd0);
    stall = 1'b0;
    flush = 1'b0;
    step();
    check("fs_post_valid",  {63'd0, mem_valid}, 64'd1);
    check("fs_post_mwrite", {63'd0, mem_memwrite}, 64'd1);
    check("fs_post_rdata2", {32'd0, mem_rdata2}, 64'h88);

    // Asynchronous reset between edges while mem_valid=1
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid",  {63'd0, mem_valid}, 64'd0);
    check("ar_mwrite", {63'd0, mem_memwrite}, 64'd0);
    check("ar_alu",    {32'd0, mem_alu_result}, 64'd0);
    check("ar_rdata2", {32'd0, mem_rdata2}, 64'd0);
    check("ar_dest",   {59'd0, mem_dest}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Reset while a taken branch is pending: no squash afterwards
    set_ex(1'b1, 2'b00, 3'b100, 32'h0000_00C0, 1'b1, 32'h0, 32'h0, 5'd0);
    step();
    check("rk_pcsrc", {63'd0, mem_pcsrc}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rk_pcsrc_clr", {63'd0, mem_pcsrc}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    set_ex(1'b1, 2'b11, 3'b010, 32'h0, 1'b0, 32'h99, 32'h0, 5'd12);
    step();
    check("rk_valid", {63'd0, mem_valid}, 64'd1);
    check("rk_alu",   {32'd0, mem_alu_result}, 64'h99);
    check("rk_dest",  {59'd0, mem_dest}, 64'd12);

`ifdef EX_MEM_PERF_EN
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("perf_rst", {32'd0, perf_bubble_count}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    set_ex(1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) step();
    check("perf_four", {32'd0, perf_bubble_count}, 64'd4);
    stall = 1'b1;
    step();
    check("perf_stall_hold", {32'd0, perf_bubble_count}, 64'd4);
    stall = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ex_mem_latch

// File: doc/ex_mem_latch.md
EX_MEM_LATCH -- requirements
Module: ex_mem_latch

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of ALU result, branch target and store data.
REQ-002 Parameter REG_AW, default 5, destination register index width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 stall  input  1  hold all registered outputs this cycle.
REQ-006 flush  input  1  replace the incoming EX instruction with a bubble.
REQ-007 ex_valid  input  1  EX stage holds a real instruction.
REQ-008 ex_wb_ctl  input  2  {regwrite, memtoreg}.
REQ-009 ex_m_ctl  input  3  {branch, memread, memwrite}.
REQ-010 ex_add_result  input  DATA_W  branch target from the execute adder.
REQ-011 ex_zero  input  1  ALU zero flag.
REQ-012 ex_alu_result  input  DATA_W  ALU result / memory address.
REQ-013 ex_rdata2  input  DATA_W  store data.
REQ-014 ex_dest  input  REG_AW  destination register index.
REQ-015 Outputs (registered, same widths/meanings, mem_ prefix): mem_valid, mem_wb_ctl, mem_branch, mem_memread, mem_memwrite, mem_add_result, mem_zero, mem_alu_result, mem_rdata2, mem_dest.
REQ-016 mem_pcsrc  output  1  taken-branch select to fetch PC mux.

Function
REQ-017 Latency: exactly one clk from EX inputs to mem_ outputs when not stalled and not bubbled.
REQ-018 Capture condition: rising edge with stall=0 and no bubble -> all mem_ outputs load EX inputs, mem_valid=1.
REQ-019 Bubble condition: flush=1, or ex_valid=0, or FSM in KILL -> mem_valid, mem_wb_ctl, mem_m_ctl bits and mem_pcsrc source cleared; data fields loaded with zero.
REQ-020 flush has priority over stall: flush=1 with stall=1 still inserts a bubble.
REQ-021 stall=1, flush=0 -> every registered output and FSM state holds its value.
REQ-022 mem_pcsrc = mem_valid & mem_branch & mem_zero, combinational from registered fields, no extra latency.
REQ-023 FSM states: RUN, KILL; reset state RUN.
REQ-024 RUN -> KILL on an unstalled edge where mem_pcsrc=1; KILL forces a bubble for that edge's capture.
REQ-025 KILL -> RUN on the next unstalled edge; KILL holds while stall=1.
REQ-026 Result: one taken branch squashes exactly one following EX instruction; mem_pcsrc high one cycle per taken branch (longer only if stalled).
REQ-027 No arithmetic performed; fields pass through unmodified at declared widths.

Reset
REQ-028 rst_n=0 asynchronously clears every output and counter to zero and forces FSM to RUN, regardless of clk.
REQ-029 Reset asserted mid-stall or in KILL discards the held instruction; first edge after release captures normally.

Configuration
REQ-030 Macro EX_MEM_PERF_EN defined -> add output perf_bubble_count  output  32, incremented on each unstalled edge that inserts a bubble, wraps 0xFFFFFFFF -> 0, reset to 0.
REQ-031 Macro undefined -> port and counter absent; all other behaviour identical.

Structure
REQ-032 Shared pipeline package holds control-field widths, bit positions for wb/m control, and the FSM state encoding.
REQ-033 Single flat module; no sub-module required.

Verification
REQ-034 ex_valid=1, ex_alu_result=0x0000_1234, ex_dest=5, ex_wb_ctl=2'b10 -> next cycle mem_alu_result=0x1234, mem_dest=5, mem_valid=1.
REQ-035 Capture, then stall=1 for 3 cycles with changing inputs -> outputs unchanged all 3 cycles.
REQ-036 ex_m_ctl branch=1, ex_zero=1, ex_add_result=0x0000_0040 -> mem_pcsrc=1, mem_add_result=0x40 one cycle; following EX instruction appears as bubble (mem_valid=0, mem_memwrite=0).
REQ-037 flush=1 and stall=1 same edge with valid memwrite input -> mem_valid=0, mem_memwrite=0.
REQ-038 rst_n dropped between edges while mem_valid=1 -> all outputs 0 immediately, FSM RUN.
REQ-039 With EX_MEM_PERF_EN, 4 unstalled edges with ex_valid=0 -> perf_bubble_count=4; preload 0xFFFFFFFF plus one bubble -> 0.
